// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC acquisition front end.
package adc_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_ARMED = 2'd1,
        M_TRACK = 2'd2
    } meas_state_t;

endpackage

// File: rtl/adc_front_end_sig_deglitch.sv
// Two-flop synchroniser followed by a hold-time deglitch filter: the output
// only follows a new level after it has been seen for GLITCH consecutive clocks.
module sig_deglitch #(
    parameter int GLITCH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(GLITCH + 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          dout_q, dout_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        cnt_d  = '0;
        dout_d = dout_q;
        // Any sample that agrees with the current output restarts the hold window.
        if (sync_q != dout_q) begin
            if (cnt_q == CW'(GLITCH - 1)) begin
                dout_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/adc_front_end.sv
// ADC clock divider, mid-period sample capture, and comparator period
// measurement with lock (stable) detection.
module adc_front_end
    import adc_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int GLITCH     = 3,
    parameter int PERIOD_W   = 24,
    parameter int TOL        = 16,
    parameter int STABLE_CNT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADC_W-1:0]    adc_data_in,
    input  logic                cmp_in,
    output logic                adc_clk,
    output logic                adc_sample_en,
    output logic [ADC_W-1:0]    sync_adc_data,
    output logic                sync_signal_in,
    output logic                stable,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam int                DIV_W      = $clog2(DIV);
    localparam int                MW         = $clog2(STABLE_CNT + 1);
    localparam int                DW         = PERIOD_W + 1;
    localparam logic [PERIOD_W-1:0] MAX_PERIOD = '1;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                adc_clk_q, adc_clk_d;
    logic                sample_en_q, sample_en_d;
    logic [ADC_W-1:0]    sync_data_q, sync_data_d;
    logic                sig_prev_q, sig_prev_d;
    meas_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] ref_q, ref_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pvalid_q, pvalid_d;
    logic [MW-1:0]       match_q, match_d;
    logic                stable_q, stable_d;

    logic                sig_clean;
    logic                adc_fall;
    logic                rise;
    logic                timeout;
    logic [DW-1:0]       diff;

    sig_deglitch #(.GLITCH(GLITCH)) u_deglitch (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmp_in),
        .dout  (sig_clean)
    );

    // adc_clk is high for div_cnt DIV/2..DIV-1, so it falls mid-period where the ADC output has settled.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        adc_clk_d = adc_clk_q ^ ((div_cnt_q == DIV_W'(DIV / 2 - 1)) ||
                                 (div_cnt_q == DIV_W'(DIV - 1)));
        adc_fall    = adc_clk_q && (div_cnt_q == DIV_W'(DIV - 1));
        sample_en_d = adc_fall;
        sync_data_d = adc_fall ? adc_data_in : sync_data_q;
    end

    always_comb begin
        sig_prev_d = sig_clean;
        rise       = sig_clean & ~sig_prev_q;
        timeout    = (pcnt_q == MAX_PERIOD);
        diff       = (pcnt_q >= ref_q) ? ({1'b0, pcnt_q} - {1'b0, ref_q})
                                       : ({1'b0, ref_q} - {1'b0, pcnt_q});
        pcnt_d     = timeout ? pcnt_q : pcnt_q + 1'b1;
        state_d    = state_q;
        ref_d      = ref_q;
        period_d   = period_q;
        pvalid_d   = 1'b0;
        match_d    = match_q;

        // A rise in the same cycle as a timeout is treated as a normal edge.
        case (state_q)
            M_IDLE: begin
                if (rise) begin
                    pcnt_d  = PERIOD_W'(1);
                    state_d = M_ARMED;
                end
            end
            M_ARMED: begin
                if (rise) begin
                    ref_d    = pcnt_q;
                    period_d = pcnt_q;
                    pvalid_d = 1'b1;
                    pcnt_d   = PERIOD_W'(1);
                    state_d  = M_TRACK;
                end else if (timeout) begin
                    match_d = '0;
                    state_d = M_IDLE;
                end
            end
            M_TRACK: begin
                if (rise) begin
                    period_d = pcnt_q;
                    pvalid_d = 1'b1;
                    pcnt_d   = PERIOD_W'(1);
                    ref_d    = pcnt_q;
                    if (diff <= DW'(TOL)) begin
                        match_d = (match_q == MW'(STABLE_CNT)) ? match_q : match_q + 1'b1;
                    end else begin
                        match_d = '0;
                    end
                end else if (timeout) begin
                    match_d = '0;
                    state_d = M_IDLE;
                end
            end
            default: begin
                match_d = '0;
                state_d = M_IDLE;
            end
        endcase

        stable_d = (match_d == MW'(STABLE_CNT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            adc_clk_q   <= 1'b0;
            sample_en_q <= 1'b0;
            sync_data_q <= '0;
            sig_prev_q  <= 1'b0;
            state_q     <= M_IDLE;
            pcnt_q      <= '0;
            ref_q       <= '0;
            period_q    <= '0;
            pvalid_q    <= 1'b0;
            match_q     <= '0;
            stable_q    <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            adc_clk_q   <= adc_clk_d;
            sample_en_q <= sample_en_d;
            sync_data_q <= sync_data_d;
            sig_prev_q  <= sig_prev_d;
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            ref_q       <= ref_d;
            period_q    <= period_d;
            pvalid_q    <= pvalid_d;
            match_q     <= match_d;
            stable_q    <= stable_d;
        end
    end

    assign adc_clk        = adc_clk_q;
    assign adc_sample_en  = sample_en_q;
    assign sync_adc_data  = sync_data_q;
    assign sync_signal_in = sig_clean;
    assign stable         = stable_q;
    assign period         = period_q;
    assign period_valid   = pvalid_q;

endmodule

// File: tb/tb_adc_front_end.sv
// Self-checking bench for adc_front_end: divider timing, capture scoreboard,
// comparator deglitch, period measurement, lock/unlock and timeout.
`timescale 1ns/1ps
module tb_adc_front_end;
    import adc_pkg::*;

    localparam int PW     = 12;
    localparam int DIV    = 4;
    localparam int MAX_P  = 4095;
    localparam int TOL    = 16;
    localparam int SCNT   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ADC_W-1:0] adc_data_in = '0;
    logic             cmp_in = 1'b0;
    logic             adc_clk;
    logic             adc_sample_en;
    logic [ADC_W-1:0] sync_adc_data;
    logic             sync_signal_in;
    logic             stable;
    logic [PW-1:0]    period;
    logic             period_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cnt  = 0;
    logic mon_en = 1'b0;
    logic adc_clk_prev = 1'b0;
    logic first_data = 1'b1;

    logic [ADC_W-1:0] exp_q[$];
    logic [PW:0]      per_q[$];

    int m_st = 0;
    int m_match = 0;
    int m_ref = 0;
    int last_rise = 0;

    adc_front_end #(
        .DIV(DIV), .GLITCH(3), .PERIOD_W(PW), .TOL(TOL), .STABLE_CNT(SCNT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_data_in    (adc_data_in),
        .cmp_in         (cmp_in),
        .adc_clk        (adc_clk),
        .adc_sample_en  (adc_sample_en),
        .sync_adc_data  (sync_adc_data),
        .sync_signal_in (sync_signal_in),
        .stable         (stable),
        .period         (period),
        .period_valid   (period_valid)
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) rel_cnt <= 0;
        else        rel_cnt <= rel_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model of the measurement path, stepped when a comparator rise is driven
    task automatic model_rise();
        int iv;
        int d;
        logic [PW:0] e;
        iv = cyc - last_rise;
        last_rise = cyc;
        if (m_st == 0) begin
            m_st = 1;
        end else if (iv > MAX_P) begin
            m_st = 1;
            m_match = 0;
        end else begin
            if (m_st == 2) begin
                d = (iv > m_ref) ? iv - m_ref : m_ref - iv;
                if (d <= TOL) m_match = (m_match == SCNT) ? SCNT : m_match + 1;
                else          m_match = 0;
            end
            m_ref = iv;
            m_st = 2;
            e = {(m_match == SCNT), iv[PW-1:0]};
            per_q.push_back(e);
        end
    endtask

    // cmp square-wave driver; called at a falling clk edge
    task automatic cmp_cycle(input int high, input int low, input logic chk_lat);
        cmp_in = 1'b1;
        model_rise();
        if (chk_lat) begin
            repeat (4) @(negedge clk);
            check_eq("deglitch_latency_4", sync_signal_in, 1'b0);
            @(negedge clk);
            check_eq("deglitch_latency_5", sync_signal_in, 1'b1);
            repeat (high - 5) @(negedge clk);
        end else begin
            repeat (high) @(negedge clk);
        end
        cmp_in = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic cmp_cycle_glitch();
        cmp_in = 1'b1;
        model_rise();
        repeat (200) @(negedge clk);
        cmp_in = 1'b0;
        repeat (2) @(negedge clk);
        cmp_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("glitch_low_ignored", sync_signal_in, 1'b1);
        end
        repeat (292) @(negedge clk);
        cmp_in = 1'b0;
        repeat (200) @(negedge clk);
        cmp_in = 1'b1;
        repeat (2) @(negedge clk);
        cmp_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("glitch_high_ignored", sync_signal_in, 1'b0);
        end
        repeat (292) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_adc_clk"},  adc_clk, 1'b0);
        check_eq({tag, "_sample"},   adc_sample_en, 1'b0);
        check_eq({tag, "_data"},     sync_adc_data, '0);
        check_eq({tag, "_sig"},      sync_signal_in, 1'b0);
        check_eq({tag, "_stable"},   stable, 1'b0);
        check_eq({tag, "_period"},   period, '0);
        check_eq({tag, "_pvalid"},   period_valid, 1'b0);
    endtask

    task automatic release_and_check_divider();
        mon_en = 1'b0;
        exp_q.delete();
        per_q.delete();
        m_st = 0;
        m_match = 0;
        adc_clk_prev = 1'b0;
        first_data = 1'b1;
        cmp_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("first_rise_adc_clk", adc_clk, 1'b1);
        check_eq("abc_at_next_rise", sync_adc_data, 12'hABC);
    endtask

    // monitor: divider timing, capture scoreboard, period scoreboard
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check_eq("adc_clk", adc_clk, (rel_cnt >= 2) && (((rel_cnt - 2) % DIV) < DIV / 2));
            check_eq("adc_sample_en", adc_sample_en, (rel_cnt >= DIV) && ((rel_cnt % DIV) == 0));
            if (adc_sample_en) begin
                check_eq("data_expected_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check_eq("sync_adc_data", sync_adc_data, exp_q.pop_front());
            end
            if (period_valid) begin
                check_eq("period_expected_pending", per_q.size() != 0, 1'b1);
                if (per_q.size() != 0) begin
                    logic [PW:0] e;
                    e = per_q.pop_front();
                    check_eq("period", period, e[PW-1:0]);
                    check_eq("stable_at_edge", stable, e[PW]);
                end
            end
            if (adc_clk && !adc_clk_prev) begin
                adc_data_in = first_data ? 12'hABC : ADC_W'($urandom_range(0, 4095));
                first_data = 1'b0;
                exp_q.push_back(adc_data_in);
            end
            adc_clk_prev = adc_clk;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int r;
        // 1: reset values and divider start-up
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        release_and_check_divider();

        // 2: square wave, period 1000, lock
        cmp_cycle(500, 500, 1'b1);
        for (int i = 0; i < 11; i++) cmp_cycle(500, 500, 1'b0);
        check_eq("locked_after_run", stable, 1'b1);

        // 3: one out-of-tolerance period, then relock
        cmp_cycle(510, 510, 1'b0);
        for (int i = 0; i < 10; i++) cmp_cycle(500, 500, 1'b0);
        check_eq("relocked", stable, 1'b1);

        // 4: short glitches on both levels
        for (int i = 0; i < 3; i++) cmp_cycle_glitch();
        check_eq("stable_after_glitches", stable, 1'b1);

        // 5: lose the comparator edge, timeout at pcnt == 4095
        cmp_in = 1'b1;
        model_rise();
        repeat (500) @(negedge clk);
        cmp_in = 1'b0;
        repeat (3550) @(negedge clk);
        check_eq("stable_before_timeout", stable, 1'b1);
        repeat (100) @(negedge clk);
        check_eq("stable_after_timeout", stable, 1'b0);
        repeat (850) @(negedge clk);
        for (int i = 0; i < 3; i++) cmp_cycle(500, 500, 1'b0);
        check_eq("no_stale_lock", stable, 1'b0);

        // 6: asynchronous reset mid-measurement while adc_clk is high
        cmp_in = 1'b1;
        model_rise();
        repeat (300) @(negedge clk);
        r = 0;
        while (adc_clk !== 1'b1 && r < 8) begin
            @(negedge clk);
            r++;
        end
        check_eq("adc_clk_high_found", adc_clk, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        release_and_check_divider();
        for (int i = 0; i < 3; i++) cmp_cycle(500, 500, 1'b0);

        repeat (20) @(negedge clk);
        check_eq("period_queue_drained", per_q.size(), 0);
        check_eq("data_queue_bounded", exp_q.size() <= 1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
